// File: rtl/multi_func_stats_pkg.sv
// Shared types and fixed-point helpers for the multi_func_stats window statistics block.
package multi_func_stats_pkg;

  typedef enum logic [1:0] {
    STATS_IDLE  = 2'd0,
    STATS_ACCUM = 2'd1,
    STATS_DONE  = 2'd2
  } stats_state_e;

  localparam int unsigned FX_FN_W = 64;

  // Largest positive two's-complement value of a given width (0111...1).
  function automatic logic [FX_FN_W-1:0] fx_max_val(input int unsigned width);
    return (FX_FN_W'(1) << (width - 1)) - FX_FN_W'(1);
  endfunction

  // Most negative two's-complement value of a given width (1000...0).
  function automatic logic [FX_FN_W-1:0] fx_min_val(input int unsigned width);
    return FX_FN_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/multi_func_stats_channel.sv
// Per-channel running sum / min / max over one window; exposes next-state values
// so the top can capture the final record on the last sample.
module stats_channel
  import multi_func_stats_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned SUM_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    update_i,
  input  logic signed [WIDTH-1:0] sample_i,
  output logic signed [SUM_W-1:0] sum_next_c,
  output logic signed [WIDTH-1:0] min_next_c,
  output logic signed [WIDTH-1:0] max_next_c
);

  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [WIDTH-1:0] min_q, min_d;
  logic signed [WIDTH-1:0] max_q, max_d;

  // Clear seeds extrema with opposite-end values; update folds in one sample.
  always_comb begin
    sum_d = sum_q;
    min_d = min_q;
    max_d = max_q;
    if (clear_i) begin
      sum_d = '0;
      min_d = WIDTH'(fx_max_val(WIDTH));
      max_d = WIDTH'(fx_min_val(WIDTH));
    end else if (update_i) begin
      sum_d = sum_q + {{(SUM_W - WIDTH){sample_i[WIDTH-1]}}, sample_i};
      if (sample_i < min_q) min_d = sample_i;
      if (sample_i > max_q) max_d = sample_i;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      min_q <= '0;
      max_q <= '0;
    end else begin
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign sum_next_c = sum_d;
  assign min_next_c = min_d;
  assign max_next_c = max_d;

endmodule

// File: rtl/multi_func_stats.sv
// Windowed sum/min/max/mean of two signed fixed-point streams with a valid/ready
// result record. Optional MULTI_FUNC_STATS_DIFF_EN adds maxdiff = max |in1 - in2|.
module multi_func_stats
  import multi_func_stats_pkg::*;
#(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned N_SAMPLES = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic                                     sample_en,
  input  logic signed [WIDTH-1:0]                  in1,
  input  logic signed [WIDTH-1:0]                  in2,
  output logic                                     busy,
  output logic                                     stats_valid,
  input  logic                                     stats_ready,
  output logic signed [WIDTH+$clog2(N_SAMPLES):0]  sum1,
  output logic signed [WIDTH+$clog2(N_SAMPLES):0]  sum2,
  output logic signed [WIDTH-1:0]                  min1,
  output logic signed [WIDTH-1:0]                  max1,
  output logic signed [WIDTH-1:0]                  min2,
  output logic signed [WIDTH-1:0]                  max2,
  output logic signed [WIDTH-1:0]                  mean1,
  output logic signed [WIDTH-1:0]                  mean2
`ifdef MULTI_FUNC_STATS_DIFF_EN
  ,
  output logic        [WIDTH:0]                    maxdiff
`endif
);

  localparam int unsigned SHIFT = $clog2(N_SAMPLES);
  localparam int unsigned CNT_W = SHIFT + 1;
  localparam int unsigned SUM_W = WIDTH + CNT_W;

  stats_state_e state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic clear_c, update_c, load_c, last_c;

  logic signed [SUM_W-1:0] ch1_sum_c, ch2_sum_c;
  logic signed [WIDTH-1:0] ch1_min_c, ch1_max_c, ch2_min_c, ch2_max_c;

  logic                    busy_q, stats_valid_q;
  logic signed [SUM_W-1:0] sum1_q, sum2_q;
  logic signed [WIDTH-1:0] min1_q, max1_q, min2_q, max2_q, mean1_q, mean2_q;

  assign last_c = (count_q == CNT_W'(N_SAMPLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= STATS_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort wins in ACCUM and DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STATS_IDLE:  if (start) state_d = STATS_ACCUM;
      STATS_ACCUM: begin
        if (abort)                    state_d = STATS_IDLE;
        else if (sample_en && last_c) state_d = STATS_DONE;
      end
      STATS_DONE: begin
        if (abort)            state_d = STATS_IDLE;
        else if (stats_ready) state_d = start ? STATS_ACCUM : STATS_IDLE;
      end
      default:                state_d = STATS_IDLE;
    endcase
  end

  // Datapath controls: window clear, sample update, record capture.
  always_comb begin
    clear_c  = 1'b0;
    update_c = 1'b0;
    load_c   = 1'b0;
    unique case (state_q)
      STATS_IDLE:  clear_c = start;
      STATS_ACCUM: begin
        update_c = !abort && sample_en;
        load_c   = !abort && sample_en && last_c;
      end
      STATS_DONE:  clear_c = !abort && stats_ready && start;
      default: ;
    endcase
  end

  // Enabled-sample counter within the window.
  always_comb begin
    count_d = count_q;
    if (clear_c)       count_d = '0;
    else if (update_c) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  stats_channel #(.WIDTH(WIDTH), .SUM_W(SUM_W)) u_ch1 (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_c),
    .update_i   (update_c),
    .sample_i   (in1),
    .sum_next_c (ch1_sum_c),
    .min_next_c (ch1_min_c),
    .max_next_c (ch1_max_c)
  );

  stats_channel #(.WIDTH(WIDTH), .SUM_W(SUM_W)) u_ch2 (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_c),
    .update_i   (update_c),
    .sample_i   (in2),
    .sum_next_c (ch2_sum_c),
    .min_next_c (ch2_min_c),
    .max_next_c (ch2_max_c)
  );

  // Status flags and the result record; the record only changes on the last sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q        <= 1'b0;
      stats_valid_q <= 1'b0;
      sum1_q        <= '0;
      sum2_q        <= '0;
      min1_q        <= '0;
      max1_q        <= '0;
      min2_q        <= '0;
      max2_q        <= '0;
      mean1_q       <= '0;
      mean2_q       <= '0;
    end else begin
      busy_q        <= (state_d == STATS_ACCUM);
      stats_valid_q <= (state_d == STATS_DONE);
      if (load_c) begin
        sum1_q  <= ch1_sum_c;
        sum2_q  <= ch2_sum_c;
        min1_q  <= ch1_min_c;
        max1_q  <= ch1_max_c;
        min2_q  <= ch2_min_c;
        max2_q  <= ch2_max_c;
        mean1_q <= WIDTH'(ch1_sum_c >>> SHIFT);
        mean2_q <= WIDTH'(ch2_sum_c >>> SHIFT);
      end
    end
  end

  assign busy        = busy_q;
  assign stats_valid = stats_valid_q;
  assign sum1        = sum1_q;
  assign sum2        = sum2_q;
  assign min1        = min1_q;
  assign max1        = max1_q;
  assign min2        = min2_q;
  assign max2        = max2_q;
  assign mean1       = mean1_q;
  assign mean2       = mean2_q;

`ifdef MULTI_FUNC_STATS_DIFF_EN
  logic signed [WIDTH:0] diff_c;
  logic        [WIDTH:0] absdiff_c;
  logic        [WIDTH:0] maxdiff_acc_q, maxdiff_acc_d;
  logic        [WIDTH:0] maxdiff_q;

  // One extra bit keeps the channel difference from wrapping.
  assign diff_c    = {in1[WIDTH-1], in1} - {in2[WIDTH-1], in2};
  assign absdiff_c = diff_c[WIDTH] ? (WIDTH+1)'(-diff_c) : (WIDTH+1)'(diff_c);

  // Running max of |in1 - in2| over the window.
  always_comb begin
    maxdiff_acc_d = maxdiff_acc_q;
    if (clear_c)                                      maxdiff_acc_d = '0;
    else if (update_c && (absdiff_c > maxdiff_acc_q)) maxdiff_acc_d = absdiff_c;
  end

  // Accumulator and the record copy, captured with the rest of the record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      maxdiff_acc_q <= '0;
      maxdiff_q     <= '0;
    end else begin
      maxdiff_acc_q <= maxdiff_acc_d;
      if (load_c) maxdiff_q <= maxdiff_acc_d;
    end
  end

  assign maxdiff = maxdiff_q;
`endif

endmodule

// File: tb/tb_multi_func_stats.sv
// Scoreboard bench for multi_func_stats (WIDTH=16, N_SAMPLES=4).
module tb_multi_func_stats;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = W + $clog2(N) + 1;

  logic clk, rst, start, abort, sample_en, stats_ready, busy, stats_valid;
  logic signed [W-1:0]  in1, in2, min1, max1, min2, max2, mean1, mean2;
  logic signed [SW-1:0] sum1, sum2;
`ifdef MULTI_FUNC_STATS_DIFF_EN
  logic [W:0] maxdiff;
`endif

  multi_func_stats #(.WIDTH(W), .N_SAMPLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .sample_en   (sample_en),
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .stats_valid (stats_valid),
    .stats_ready (stats_ready),
    .sum1        (sum1),
    .sum2        (sum2),
    .min1        (min1),
    .max1        (max1),
    .min2        (min2),
    .max2        (max2),
    .mean1       (mean1),
    .mean2       (mean2)
`ifdef MULTI_FUNC_STATS_DIFF_EN
    ,
    .maxdiff     (maxdiff)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint sum1, min1, max1, mean1, sum2, min2, max2, mean2, md;
  } rec_t;
  typedef enum {M_IDLE, M_ACCUM, M_DONE} mstate_e;

  rec_t        exp_q[$];
  rec_t        last_rec;
  mstate_e     m_state;
  longint      m_sum1, m_min1, m_max1, m_sum2, m_min2, m_max2, m_md;
  int unsigned m_cnt;
  int          n_total = 0;
  int          n_bad   = 0;
  bit          valid_prev;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint s);
    longint q;
    q = s / longint'(N);
    if ((s % longint'(N) != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic chk_rec(input string p, input rec_t r);
    chk({p, "_sum1"},  longint'(sum1),  r.sum1);
    chk({p, "_min1"},  longint'(min1),  r.min1);
    chk({p, "_max1"},  longint'(max1),  r.max1);
    chk({p, "_mean1"}, longint'(mean1), r.mean1);
    chk({p, "_sum2"},  longint'(sum2),  r.sum2);
    chk({p, "_min2"},  longint'(min2),  r.min2);
    chk({p, "_max2"},  longint'(max2),  r.max2);
    chk({p, "_mean2"}, longint'(mean2), r.mean2);
`ifdef MULTI_FUNC_STATS_DIFF_EN
    chk({p, "_maxdiff"}, longint'(maxdiff), r.md);
`endif
  endtask

  task automatic m_clear();
    m_sum1 = 0; m_sum2 = 0; m_cnt = 0; m_md = 0;
    m_min1 = 32767;  m_min2 = 32767;
    m_max1 = -32768; m_max2 = -32768;
  endtask

  task automatic m_push();
    rec_t r;
    r.sum1 = m_sum1; r.min1 = m_min1; r.max1 = m_max1; r.mean1 = floor_div(m_sum1);
    r.sum2 = m_sum2; r.min2 = m_min2; r.max2 = m_max2; r.mean2 = floor_div(m_sum2);
    r.md   = m_md;
    exp_q.push_back(r);
  endtask

  // Drive one cycle of inputs and advance the reference model to the post-edge state.
  task automatic drive(input bit st, input bit en, input int a, input int b,
                       input bit rdy, input bit ab);
    longint d;
    start = st; sample_en = en; in1 = W'(a); in2 = W'(b); stats_ready = rdy; abort = ab;
    case (m_state)
      M_IDLE: if (st) begin m_clear(); m_state = M_ACCUM; end
      M_ACCUM: begin
        if (ab) m_state = M_IDLE;
        else if (en) begin
          m_sum1 += a; m_sum2 += b;
          if (a < m_min1) m_min1 = a;
          if (a > m_max1) m_max1 = a;
          if (b < m_min2) m_min2 = b;
          if (b > m_max2) m_max2 = b;
          d = longint'(a) - longint'(b);
          if (d < 0) d = -d;
          if (d > m_md) m_md = d;
          m_cnt++;
          if (m_cnt == N) begin m_push(); m_state = M_DONE; end
        end
      end
      default: begin
        if (ab) m_state = M_IDLE;
        else if (rdy) begin
          if (st) begin m_clear(); m_state = M_ACCUM; end
          else m_state = M_IDLE;
        end
      end
    endcase
  endtask

  // Advance one clock and check status, scoreboard record and held outputs.
  task automatic tick();
    rec_t r;
    @(posedge clk);
    #1;
    chk("busy",  longint'(busy),        longint'(m_state == M_ACCUM));
    chk("valid", longint'(stats_valid), longint'(m_state == M_DONE));
    if (stats_valid && !valid_prev) begin
      if (exp_q.size() == 0) chk("spurious_valid", longint'(exp_q.size()), 1);
      else begin
        r = exp_q.pop_front();
        chk_rec("rec", r);
        last_rec = r;
      end
    end
    valid_prev = stats_valid;
    chk_rec("hold", last_rec);
  endtask

  task automatic feed(input int a[4], input int b[4], input bit gap);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, a[i], b[i], 0, 0); tick();
      if (gap) begin drive(0, 0, 99, -99, 0, 0); tick(); end
    end
  endtask

  task automatic handshake_idle();
    drive(0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; sample_en = 1'b0;
    in1 = '0; in2 = '0; stats_ready = 1'b0;
    m_state = M_IDLE; last_rec = '{default: 0}; valid_prev = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", longint'(stats_valid), 0);
    chk("rst_busy",  longint'(busy), 0);
    chk_rec("rst", last_rec);
    rst = 1'b1;
    drive(0, 1, 7, 7, 0, 1); tick();                    // IDLE ignores samples and abort

    // Basic window
    drive(1, 0, 0, 0, 0, 0); tick();
    feed('{10, -3, 7, 2}, '{-5, -5, -5, -5}, 0);
    handshake_idle();

    // Gapped enables, identical data
    drive(1, 0, 0, 0, 0, 0); tick();
    feed('{10, -3, 7, 2}, '{-5, -5, -5, -5}, 1);
    handshake_idle();

    // Backpressure, samples in DONE dropped, then back-to-back restart
    drive(1, 0, 0, 0, 0, 0); tick();
    feed('{-100, 1000, 3, 4}, '{1, 2, 3, 4}, 0);
    for (int i = 0; i < 5; i++) begin drive(0, 1, 77, -77, 0, 0); tick(); end
    drive(1, 0, 0, 0, 1, 0); tick();
    feed('{5, 6, 7, 8}, '{9, 9, 9, 9}, 0);
    handshake_idle();

    // Extremes and floor of a negative mean
    drive(1, 0, 0, 0, 0, 0); tick();
    feed('{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}, 0);
    handshake_idle();
    drive(1, 0, 0, 0, 0, 0); tick();
    feed('{-32768, -32768, -32768, -32768}, '{-2, -1, -1, -1}, 0);
    handshake_idle();

    // Abort mid-window, then a clean window started with abort high in IDLE
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 30000, -30000, 0, 0); tick(); end
    drive(0, 1, 30000, -30000, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1); tick();
    feed('{100, -1, 0, 1}, '{-100, 0, 0, 0}, 0);
    handshake_idle();

    // Abort while the record is pending
    drive(1, 0, 0, 0, 0, 0); tick();
    feed('{1, 2, 3, 5}, '{4, 4, 4, -4}, 0);
    drive(1, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 0); tick();

    // Reset in the middle of a window
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 11, 12, 0, 0); tick();
    drive(0, 1, 13, 14, 0, 0); tick();
    #2 rst = 1'b0;
    #1;
    last_rec = '{default: 0};
    chk("midrst_valid", longint'(stats_valid), 0);
    chk("midrst_busy",  longint'(busy), 0);
    chk_rec("midrst", last_rec);
    m_state = M_IDLE; exp_q.delete(); valid_prev = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(0, 1, 5, 5, 1, 0); tick(); end

    chk("queue_empty", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_func_stats.md
Name: multi_func_stats

Overview:
- Downstream consumer of the dual-output msdsl model test harness.
- Takes the model's two fixed-point outputs (out1, out2) as raw signed svreal words.
- Over a window of N_SAMPLES enabled samples, accumulates per-channel sum, min, max and mean, then presents one result record through a valid/ready handshake.
- Gives the bench a synthesizable, cycle-accurate summary of model output, usable on FPGA emulation without per-sample readback.

Parameters:
- WIDTH, 18: signed fixed-point word width of in1/in2; matches the svreal width of out1_int/out2_int.
- N_SAMPLES, 16: window length in enabled samples; must be a power of two, ≥2.
- CNT_W, $clog2(N_SAMPLES)+1: counter and sum-extension width (derived; do not override).

Ports:
- clk, input, 1: single clock; all state is on its rising edge.
- rst, input, 1: asynchronous active-low reset.
- start, input, 1: begin a new window; sampled in IDLE, and in DONE on the handshake cycle.
- abort, input, 1: discard the current window and return to IDLE.
- sample_en, input, 1: in1/in2 are valid this cycle.
- in1, input, WIDTH: signed fixed-point sample, channel 1 (model out1).
- in2, input, WIDTH: signed fixed-point sample, channel 2 (model out2).
- busy, output, 1: high in ACCUM.
- stats_valid, output, 1: result record valid.
- stats_ready, input, 1: consumer accepts the record.
- sum1, sum2, output, WIDTH+CNT_W: signed window sums.
- min1, max1, min2, max2, output, WIDTH: signed window extrema.
- mean1, mean2, output, WIDTH: sum arithmetically shifted right by log2(N_SAMPLES), which floors toward −inf.

Behaviour:
- Reset (rst=0, async):
  - State → IDLE.
  - All outputs and internal registers → 0; stats_valid=0, busy=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 → ACCUM next cycle.
  - On entry to ACCUM: count=0, sums=0, min regs=+max representable (0111…1), max regs=−min representable (1000…0).
  - sample_en in IDLE is ignored.
- ACCUM: on each cycle with sample_en=1:
  - sum += sign-extended sample.
  - min = smaller of (min, sample); max = larger of (max, sample).
  - count += 1.
  - The sample with count==N_SAMPLES-1 is the last. Next cycle: state → DONE, stats_valid=1, all result outputs registered.
  - Latency from the last sample to stats_valid is 1 cycle.
- ACCUM ignores start.
- DONE:
  - Outputs are held stable while stats_valid=1 and stats_ready=0.
  - Handshake fires on stats_valid && stats_ready.
  - Next state after the handshake: ACCUM (fresh clear) if start=1 in the same cycle, else IDLE.
  - stats_valid drops the cycle after the handshake.
  - sample_en in DONE is ignored (samples are dropped).
- abort:
  - Overrides everything in ACCUM and DONE: next state IDLE, stats_valid=0, result outputs retain their last values.
  - No effect in IDLE.
- Arithmetic: sums cannot overflow by construction (CNT_W guard bits). Extrema use signed compare. Outputs are raw fixed-point at the same exponent as the inputs.
- Equal values in min/max compare: register is unchanged; either outcome gives the same result.

Optional Feature:
- Macro: MULTI_FUNC_STATS_DIFF_EN.
- Defined:
  - Adds output maxdiff (WIDTH+1 bits, unsigned) = max over the window of |in1 − in2|.
  - Computed at WIDTH+1 bits, so it never wraps.
  - Cleared to 0 on window start; registered and handshaked with the rest of the record.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package multi_func_stats_pkg holds:
  - state enum: STATS_IDLE, STATS_ACCUM, STATS_DONE.
  - functions fx_max_val(width) and fx_min_val(width).
- Sub-module stats_channel (one instance per channel) holds the sum/min/max registers, with clear and update inputs.
- Top level holds the FSM, counter, handshake and mean shift.

Test Plan:
- Reset mid-window: WIDTH=16, N=4; start, feed 2 samples, pull rst low → immediately stats_valid=0, busy=0, all outputs 0; after release, stays IDLE.
- Basic window: in1=10,−3,7,2 and in2=−5,−5,−5,−5 with sample_en every cycle → 1 cycle after the 4th sample: sum1=16, min1=−3, max1=10, mean1=4; sum2=−20, min2=max2=−5, mean2=−5.
- Gapped enables: same data as the basic window with sample_en toggling 1,0,1,0… → identical results; stats_valid arrives 1 cycle after the 4th enabled sample.
- Backpressure: hold stats_ready=0 for 5 cycles → outputs stable, stats_valid=1 throughout. Then ready=1 with start=1 → next window begins with no IDLE cycle; extrema are re-initialised.
- Extremes: in1=32767 ×4 → sum1=131068, mean1=32767. in1=−32768 ×4 → min1=max1=−32768, mean1=−32768. Also check mean floor: sum −5 over N=4 → mean −2.
- Abort: abort after 3 samples → IDLE, no stats_valid; the following window is unaffected by the aborted data. With MULTI_FUNC_STATS_DIFF_EN: in1=100, in2=−100 → maxdiff=200.
